// File: rtl/hdmi_timing_pkg.sv
// Shared constants, widths and state type for the HDMI raster timing path.
// Defaults describe CEA-861 1280x720p60 on a 74.25 MHz pixel clock.
package hdmi_timing_pkg;

   localparam int unsigned H_ACTIVE_720P = 1280;
   localparam int unsigned H_FP_720P     = 110;
   localparam int unsigned H_SYNC_720P   = 40;
   localparam int unsigned H_BP_720P     = 220;
   localparam int unsigned V_ACTIVE_720P = 720;
   localparam int unsigned V_FP_720P     = 5;
   localparam int unsigned V_SYNC_720P   = 5;
   localparam int unsigned V_BP_720P     = 20;

   localparam int unsigned H_TOTAL_720P =
      H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
   localparam int unsigned V_TOTAL_720P =
      V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

   localparam int unsigned X_W = 11;
   localparam int unsigned Y_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RUN
   } vt_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 while enabled.
// tc pulses on the enabled cycle that wraps back to zero.
module timing_axis_counter #(
   parameter int unsigned TOTAL = 1650,
   parameter int unsigned W     = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   assign tc = en && (cnt == LAST);

   // Count on enable, wrap at the last position, clear when idle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/video_timing_720p.sv
// Raster timing generator: waits for a settled PLL lock, then scans
// h/v counters and emits registered sync, de, coordinates and strobes.
module video_timing_720p
   import hdmi_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE      = H_ACTIVE_720P,
   parameter int unsigned H_FP          = H_FP_720P,
   parameter int unsigned H_SYNC        = H_SYNC_720P,
   parameter int unsigned H_BP          = H_BP_720P,
   parameter int unsigned V_ACTIVE      = V_ACTIVE_720P,
   parameter int unsigned V_FP          = V_FP_720P,
   parameter int unsigned V_SYNC        = V_SYNC_720P,
   parameter int unsigned V_BP          = V_BP_720P,
   parameter bit          HSYNC_POL     = 1'b1,
   parameter bit          VSYNC_POL     = 1'b1,
   parameter int unsigned SETTLE_CYCLES = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           lock,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           line_start,
   output logic           frame_start,
   output logic           running
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW = cnt_w(H_TOTAL);
   localparam int unsigned VW = cnt_w(V_TOTAL);
   localparam int unsigned SW = cnt_w(SETTLE_CYCLES);

   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_geom_check
      $error("video_timing_720p: raster exceeds coordinate port width");
   end

   vt_state_t      state;
   logic [SW-1:0]  settle_cnt;
   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic           h_tc;
   logic           v_tc_unused;
   logic           run;
   logic           act;
   logic           hs_on;
   logic           vs_on;

   assign run   = (state == RUN);
   assign act   = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign hs_on = run && (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
   assign vs_on = run && (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);

   timing_axis_counter #(
      .TOTAL (H_TOTAL),
      .W     (HW)
   ) u_h_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!run),
      .en  (run),
      .cnt (h_cnt),
      .tc  (h_tc)
   );

   timing_axis_counter #(
      .TOTAL (V_TOTAL),
      .W     (VW)
   ) u_v_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!run),
      .en  (h_tc),
      .cnt (v_cnt),
      .tc  (v_tc_unused)
   );

   // Lock qualifier FSM: settle window after lock, abort on any lock loss.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         running    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               settle_cnt <= '0;
               if (lock) state <= SETTLE;
            end
            SETTLE: begin
               if (!lock) begin
                  state      <= IDLE;
                  settle_cnt <= '0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state      <= RUN;
                  running    <= 1'b1;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            RUN: begin
               if (!lock) begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               settle_cnt <= '0;
               running    <= 1'b0;
            end
         endcase
      end
   end

   // Registered raster decode, one cycle behind the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
         de          <= act;
         line_start  <= act && (h_cnt == '0);
         frame_start <= act && (h_cnt == '0) && (v_cnt == '0);
         if (act) begin
            x <= X_W'(h_cnt);
            y <= Y_W'(v_cnt);
         end else if (!run) begin
            x <= '0;
            y <= '0;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_720p.sv
// Bench for video_timing_720p on a reduced raster so frames stay short.
// A cycle model feeds a scoreboard; scenario tasks add timing measurements.
module tb_video_timing_720p;

   localparam int HA = 16;
   localparam int HF = 4;
   localparam int HS = 3;
   localparam int HB = 5;
   localparam int VA = 6;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int SETTLE = 20;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam bit HP = 1'b1;
   localparam bit VP = 1'b0;

   localparam int RUN_B = 26;
   localparam int FS_B = 25;
   localparam int LS_B = 24;
   localparam int DE_B = 2;
   localparam int VS_B = 1;
   localparam int HS_B = 0;

   typedef logic [26:0] snap_t;

   localparam snap_t RST_SNAP =
      {1'b0, 1'b0, 1'b0, 10'd0, 11'd0, 1'b0, ~VP, ~HP};
   localparam snap_t FIRST_SNAP =
      {1'b1, 1'b1, 1'b1, 10'd0, 11'd0, 1'b1, ~VP, ~HP};

   logic        clk;
   logic        rst;
   logic        lock;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [10:0] x;
   logic [9:0]  y;
   logic        line_start;
   logic        frame_start;
   logic        running;

   int    errors = 0;
   int    checks = 0;
   snap_t sb[$];
   snap_t obs;
   snap_t exp_s;

   logic m_run = 1'b0;
   int   m_t = 0;
   int   m_hi = 0;
   int   m_x = 0;
   int   m_y = 0;

   video_timing_720p #(
      .H_ACTIVE      (HA),
      .H_FP          (HF),
      .H_SYNC        (HS),
      .H_BP          (HB),
      .V_ACTIVE      (VA),
      .V_FP          (VF),
      .V_SYNC        (VS),
      .V_BP          (VB),
      .HSYNC_POL     (HP),
      .VSYNC_POL     (VP),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lock        (lock),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .x           (x),
      .y           (y),
      .line_start  (line_start),
      .frame_start (frame_start),
      .running     (running)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle model: predicts the registered outputs after every edge.
   always @(posedge clk) begin : model
      int   p;
      int   h;
      int   v;
      logic act;
      logic hs_b;
      logic vs_b;
      logic ls;
      p = m_t % FRAME;
      h = p % HT;
      v = p / HT;
      if (rst) begin
         m_run = 1'b0;
         m_hi = 0;
         m_x = 0;
         m_y = 0;
         sb.push_back(RST_SNAP);
      end else begin
         act = m_run && h < HA && v < VA;
         hs_b = (m_run && h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
         vs_b = (m_run && v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
         ls = act && h == 0;
         if (act) begin
            m_x = h;
            m_y = v;
         end else if (!m_run) begin
            m_x = 0;
            m_y = 0;
         end
         if (m_run) begin
            if (!lock) begin
               m_run = 1'b0;
               m_hi = 0;
            end else begin
               m_t = m_t + 1;
            end
         end else begin
            m_hi = lock ? m_hi + 1 : 0;
            if (m_hi == SETTLE + 1) begin
               m_run = 1'b1;
               m_t = 0;
               m_hi = 0;
            end
         end
         sb.push_back({m_run, ls && v == 0, ls, 10'(m_y), 11'(m_x),
                       act, vs_b, hs_b});
      end
   end

   function automatic snap_t pins();
      return {running, frame_start, line_start, y, x, de, vsync, hsync};
   endfunction

   // Advance one cycle and fetch the observed and predicted snapshots.
   task automatic tick();
      @(negedge clk);
      obs = pins();
      if (sb.size() != 0) exp_s = sb.pop_front();
      else exp_s = 'x;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      lock = 1'b1;
      repeat (4) begin
         tick();
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_reset t=%0t got=%h want=%h", $time, obs, exp_s);
         end
         checks++;
         if (obs !== RST_SNAP) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs, RST_SNAP);
         end
      end
   endtask

   // Counts cycles from the current rst/lock drive until running rises.
   task automatic test_bring_up(input string tag);
      int n;
      rst = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_up_%s t=%0t got=%h want=%h",
                     tag, $time, obs, exp_s);
         end
      end while (obs[RUN_B] !== 1'b1 && n < SETTLE + 10);
      checks++;
      if (n != SETTLE + 1) begin
         errors++;
         $display("FAIL settle_len_%s got=%0d want=%0d", tag, n, SETTLE + 1);
      end
      tick();
      checks++;
      if (obs !== exp_s) begin
         errors++;
         $display("FAIL sb_up_%s t=%0t got=%h want=%h",
                  tag, $time, obs, exp_s);
      end
      checks++;
      if (obs !== FIRST_SNAP) begin
         errors++;
         $display("FAIL first_pixel_%s got=%h want=%h", tag, obs, FIRST_SNAP);
      end
   endtask

   task automatic test_line_frame();
      int   t;
      int   lt;
      int   de_ln;
      int   de_fr;
      int   hs_len;
      int   vs_len;
      logic hs_prev;
      logic vs_prev;
      logic hs_a;
      logic vs_a;
      t = 0;
      lt = 0;
      de_ln = 1;
      de_fr = 1;
      hs_len = 0;
      vs_len = 0;
      hs_prev = (obs[HS_B] == HP);
      vs_prev = (obs[VS_B] == VP);
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_frame t=%0t got=%h want=%h", $time, obs, exp_s);
         end
         t++;
         lt++;
         if (obs[LS_B]) begin
            if (!obs[FS_B]) begin
               checks++;
               if (lt != HT) begin
                  errors++;
                  $display("FAIL line_period got=%0d want=%0d", lt, HT);
               end
            end
            checks++;
            if (de_ln != HA) begin
               errors++;
               $display("FAIL de_per_line got=%0d want=%0d", de_ln, HA);
            end
            lt = 0;
            de_ln = 0;
         end
         if (obs[FS_B]) begin
            checks++;
            if (t != FRAME) begin
               errors++;
               $display("FAIL frame_period got=%0d want=%0d", t, FRAME);
            end
            checks++;
            if (de_fr != HA * VA) begin
               errors++;
               $display("FAIL de_per_frame got=%0d want=%0d", de_fr, HA * VA);
            end
            checks++;
            if (vs_len != VS * HT) begin
               errors++;
               $display("FAIL vsync_len got=%0d want=%0d", vs_len, VS * HT);
            end
            t = 0;
            de_fr = 0;
            vs_len = 0;
         end
         if (obs[DE_B]) begin
            de_ln++;
            de_fr++;
         end
         hs_a = (obs[HS_B] == HP);
         if (hs_a && !hs_prev) begin
            checks++;
            if (lt % HT != HA + HF) begin
               errors++;
               $display("FAIL hsync_start got=%0d want=%0d", lt % HT, HA + HF);
            end
         end
         if (!hs_a && hs_prev) begin
            checks++;
            if (hs_len != HS) begin
               errors++;
               $display("FAIL hsync_len got=%0d want=%0d", hs_len, HS);
            end
            hs_len = 0;
         end
         if (hs_a) hs_len++;
         hs_prev = hs_a;
         vs_a = (obs[VS_B] == VP);
         if (vs_a && !vs_prev) begin
            checks++;
            if (t != (VA + VF) * HT) begin
               errors++;
               $display("FAIL vsync_start got=%0d want=%0d",
                        t, (VA + VF) * HT);
            end
         end
         if (vs_a) vs_len++;
         vs_prev = vs_a;
      end
   endtask

   task automatic test_lock_loss();
      int n;
      n = 0;
      while (!(m_run && (m_t % FRAME) == 3 * HT + 10) && n < 2 * FRAME) begin
         tick();
         n++;
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_loss t=%0t got=%h want=%h", $time, obs, exp_s);
         end
      end
      checks++;
      if (n >= 2 * FRAME) begin
         errors++;
         $display("FAIL loss_wait got=%0d want<%0d", n, 2 * FRAME);
      end
      lock = 1'b0;
      tick();
      checks++;
      if (obs !== exp_s) begin
         errors++;
         $display("FAIL sb_loss t=%0t got=%h want=%h", $time, obs, exp_s);
      end
      checks++;
      if ({obs[RUN_B], obs[DE_B]} !== 2'b01) begin
         errors++;
         $display("FAIL loss_edge1 got=%b want=01", {obs[RUN_B], obs[DE_B]});
      end
      tick();
      checks++;
      if (obs !== exp_s) begin
         errors++;
         $display("FAIL sb_loss t=%0t got=%h want=%h", $time, obs, exp_s);
      end
      checks++;
      if ({obs[RUN_B], obs[DE_B], obs[VS_B], obs[HS_B]} !==
          {1'b0, 1'b0, ~VP, ~HP}) begin
         errors++;
         $display("FAIL loss_edge2 got=%b want=%b",
                  {obs[RUN_B], obs[DE_B], obs[VS_B], obs[HS_B]},
                  {1'b0, 1'b0, ~VP, ~HP});
      end
      repeat (3) begin
         tick();
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_loss t=%0t got=%h want=%h", $time, obs, exp_s);
         end
      end
      lock = 1'b1;
   endtask

   task automatic test_settle_glitch();
      lock = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_glitch t=%0t got=%h want=%h", $time, obs, exp_s);
         end
      end
      lock = 1'b1;
      repeat (11) begin
         tick();
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_glitch t=%0t got=%h want=%h", $time, obs, exp_s);
         end
         checks++;
         if (obs[RUN_B] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_running got=%b want=0", obs[RUN_B]);
         end
      end
      lock = 1'b0;
      tick();
      checks++;
      if (obs !== exp_s) begin
         errors++;
         $display("FAIL sb_glitch t=%0t got=%h want=%h", $time, obs, exp_s);
      end
      lock = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (!(m_run && (m_t % FRAME) == 4 * HT + 5) && n < 2 * FRAME) begin
         tick();
         n++;
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_rstmid t=%0t got=%h want=%h", $time, obs, exp_s);
         end
      end
      checks++;
      if (n >= 2 * FRAME) begin
         errors++;
         $display("FAIL rstmid_wait got=%0d want<%0d", n, 2 * FRAME);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (obs !== exp_s) begin
         errors++;
         $display("FAIL sb_rstmid t=%0t got=%h want=%h", $time, obs, exp_s);
      end
      checks++;
      if (obs !== RST_SNAP) begin
         errors++;
         $display("FAIL rstmid_state got=%h want=%h", obs, RST_SNAP);
      end
   endtask

   task automatic test_drop_at_wrap();
      int n;
      n = 0;
      while (!(m_run && (m_t % FRAME) == FRAME - 1) && n < 2 * FRAME) begin
         tick();
         n++;
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_wrap t=%0t got=%h want=%h", $time, obs, exp_s);
         end
      end
      checks++;
      if (n >= 2 * FRAME) begin
         errors++;
         $display("FAIL wrap_wait got=%0d want<%0d", n, 2 * FRAME);
      end
      lock = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if (obs !== exp_s) begin
            errors++;
            $display("FAIL sb_wrap t=%0t got=%h want=%h", $time, obs, exp_s);
         end
         checks++;
         if (obs[FS_B] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_frame_start got=%b want=0", obs[FS_B]);
         end
      end
      checks++;
      if (obs[RUN_B] !== 1'b0) begin
         errors++;
         $display("FAIL wrap_running got=%b want=0", obs[RUN_B]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t limit=2000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      lock = 1'b0;
      test_reset();
      test_bring_up("boot");
      test_line_frame();
      test_lock_loss();
      test_bring_up("relock");
      test_settle_glitch();
      test_bring_up("glitch");
      test_reset_mid();
      test_bring_up("rst");
      test_drop_at_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
